// File: rtl/apb_noc_pkg.sv
// Purpose : shared APB/NoC definitions: FSM state encoding, default bus widths, wait-state helper.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: apb_state_e (IDLE=0, SETUP=1, ACCESS=2), APB_ADDR_W/APB_DATA_W defaults used by
//           both the NoC APB master and the register-file completer, apb_eff_wait() clamp.
package apb_noc_pkg;

  localparam int          APB_ADDR_W   = 8;
  localparam int          APB_DATA_W   = 8;
  // The wait counter in the completer is 4 bits wide.
  localparam int unsigned APB_WAIT_MAX = 15;

  // The encoding is shared with the master. The completer never rests in SETUP.
  // It takes the setup phase on the accept edge so that a zero-wait transfer still
  // finishes in the standard two bus cycles with a registered PREADY.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Effective number of PREADY-low access cycles. It is zero when wait states are
  // compiled out, and it is clamped to what the 4-bit counter can hold.
  function automatic int unsigned apb_eff_wait(input int unsigned cycles, input bit en);
    if (!en) begin
      return 0;
    end
    return (cycles > APB_WAIT_MAX) ? APB_WAIT_MAX : cycles;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// Purpose : DEPTH x DATA_W register array behind the APB completer.
// Latency : write commits on the clock edge; read is combinational from idx_i.
// Backpr. : none, every request is taken; the caller gates we_i.
// Ports   : clk_i/reset_i (sync, active-high clear of every entry), we_i/idx_i/wdata_i write
//           port, rdata_o combinational read of entry idx_i (same index as the write port).
module apb_regfile_mem #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // An out-of-range index only occurs when the top has already flagged an error.
  // In that case the top discards rdata_o.
  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// Purpose : APB completer serving a DEPTH x DATA_W register file at a NoC endpoint.
// Latency : setup in cycle N, pready in cycle N+1+W (W = WAIT_CYCLES with APB_SLV_WAIT_EN, else 0).
// Backpr. : stalls the master by holding pready low for W access cycles; psel drop aborts the transfer.
// Config  : `define APB_SLV_WAIT_EN to enable programmable wait states. Without it the
//           transfer is zero-wait and the counter and latches are absent.
// Ports   : clk, reset (sync, active-high); psel/penable/pwrite/paddr/pwdata from the master;
//           pready (one-cycle registered strobe), prdata (read data, 0 on writes/errors),
//           pslverr (out-of-range address or penable without setup), both valid with pready.
module apb_slave_regfile
  import apb_noc_pkg::*;
#(
  parameter int          ADDR_W      = APB_ADDR_W,
  parameter int          DATA_W      = APB_DATA_W,
  parameter int          DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

`ifdef APB_SLV_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int unsigned WAIT_EFF = apb_eff_wait(WAIT_CYCLES, WAIT_EN);
  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Registered FSM state and outputs.
  apb_state_e        state_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

`ifdef APB_SLV_WAIT_EN
  // The transfer is captured at setup so that bus changes during the wait states are ignored.
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
`endif

  // Decode and next-state values for the response registers.
  logic              accept;
  logic              proto_err;
  logic              abort;
  logic              finish;
  logic              complete;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_write;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              pslverr_d;
  logic [DATA_W-1:0] prdata_d;

  always_comb begin
    // A setup is taken from IDLE or from the completion cycle. The second case allows
    // back-to-back transfers even if the master drops penable early.
    accept    = psel && !penable &&
                ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready_q));
    proto_err = psel && penable && (state_q == ST_IDLE);

`ifdef APB_SLV_WAIT_EN
    abort     = (state_q == ST_ACCESS) && !pready_q && !psel;
    finish    = (state_q == ST_ACCESS) && !pready_q && psel && (cnt_q <= 4'd1);
    cur_addr  = accept ? paddr  : addr_q;
    cur_write = accept ? pwrite : write_q;
    cur_wdata = accept ? pwdata : wdata_q;
`else
    // ACCESS without pready cannot occur in the zero-wait build.
    // If it ever does, this term returns the FSM to IDLE.
    abort     = (state_q == ST_ACCESS) && !pready_q;
    finish    = 1'b0;
    cur_addr  = paddr;
    cur_write = pwrite;
    cur_wdata = pwdata;
`endif

    // With zero waits the response is decided on the accept edge itself.
    complete  = (accept && (WAIT_EFF == 0)) || finish;
    cur_ok    = (32'(cur_addr) < 32'(DEPTH));
    mem_idx   = cur_addr[IDX_W-1:0];
    mem_we    = complete && cur_write && cur_ok;
    pslverr_d = complete && !cur_ok;
    prdata_d  = (complete && !cur_write && cur_ok) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
`endif
    end else if (accept) begin
      state_q   <= ST_ACCESS;
      pready_q  <= complete;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= 4'(WAIT_EFF);
      addr_q    <= paddr;
      write_q   <= pwrite;
      wdata_q   <= pwdata;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // penable without a preceding setup: flag the error and do nothing else.
          if (proto_err) begin
            state_q   <= ST_ACCESS;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end
        end
        ST_ACCESS: begin
          if (pready_q || abort) begin
            // The response is held for exactly one cycle, then everything returns to zero.
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
          end else if (finish) begin
            pready_q  <= 1'b1;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
          end
`ifdef APB_SLV_WAIT_EN
          else begin
            cnt_q <= cnt_q - 4'd1;
          end
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
        end
      endcase
    end
  end

  apb_regfile_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Purpose : scoreboard bench for apb_slave_regfile; the driver queues the expected response
//           and the monitor pops and checks it whenever pready is seen.
// Checks  : response cycle, prdata, pslverr per transfer; outputs quiet between transfers.
module tb_apb_slave_regfile;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int W = WAIT_CYCLES;
`else
  localparam int W = 0;
`endif

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [ADDR_W-1:0] paddr   = '0;
  logic [DATA_W-1:0] pwdata  = '0;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  typedef struct {
    int               cyc;
    logic [DATA_W-1:0] rdata;
    logic             err;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;

  apb_slave_regfile #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int at_cyc, input logic [DATA_W-1:0] rd, input logic err,
                            input string name);
    exp_t e;
    e.cyc   = at_cyc;
    e.rdata = rd;
    e.err   = err;
    e.name  = name;
    sb.push_back(e);
  endtask

  // The monitor pops one expected entry per pready. It also requires the outputs to be quiet otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (pready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: cycle %0d, got pready=1, expected none outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_cycle"},   cyc,     e.cyc);
          chk({e.name, "_prdata"},  prdata,  e.rdata);
          chk({e.name, "_pslverr"}, pslverr, e.err);
        end
      end else begin
        chk("idle_outputs", {pready, pslverr, prdata}, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The task is entered and left at posedge+1. The bus is idle on exit, so the next call runs back to back.
  // The address and data are scrambled during access to check that the setup values were latched.
  task automatic xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W-1:0] exp_rd, input logic exp_err, input string name);
    bit seen;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    expect_rsp(cyc + 1 + W, exp_rd, exp_err, name);
    @(posedge clk);
    #1;
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~d;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready in 40 cycles, expected one", name);
    end else begin
      @(posedge clk);
      #1;
    end
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_pready",  pready,  0);
    chk("reset_pslverr", pslverr, 0);
    chk("reset_prdata",  prdata,  0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read and the last valid address.
    xfer(1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, "wr_a5_03");
    idle(1);
    xfer(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, "rd_03");
    xfer(1'b1, 8'h3F, 8'h3C, 8'h00, 1'b0, "wr_3c_3f");
    xfer(1'b0, 8'h3F, 8'h00, 8'h3C, 1'b0, "rd_3f");
    idle(2);

    // Addresses at and beyond DEPTH.
    xfer(1'b1, 8'h40, 8'h99, 8'h00, 1'b1, "wr_40_err");
    xfer(1'b0, 8'h40, 8'h00, 8'h00, 1'b1, "rd_40_err");
    xfer(1'b1, 8'hFF, 8'h5C, 8'h00, 1'b1, "wr_ff_err");
    idle(1);

    // Back-to-back write then read with no idle cycle.
    xfer(1'b1, 8'h00, 8'h11, 8'h00, 1'b0, "b2b_wr_00");
    xfer(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, "b2b_rd_00");
    idle(1);

    // penable without setup: one-cycle error response, and register 0x03 must keep 0xA5.
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h03;
    pwdata  = 8'hEE;
    expect_rsp(cyc + 1, 8'h00, 1'b1, "proto_err");
    idle(2);
    psel    = 1'b0;
    penable = 1'b0;
    idle(1);
    xfer(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, "rd_03_after_proto");
    xfer(1'b0, 8'h02, 8'h00, 8'h00, 1'b0, "rd_02_unwritten");
    idle(1);

`ifdef APB_SLV_WAIT_EN
    // psel is dropped during a wait state, so no response is given and no write happens.
    xfer(1'b1, 8'h01, 8'h77, 8'h00, 1'b0, "wr_77_01");
    idle(1);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h01;
    pwdata  = 8'h22;
    idle(1);
    penable = 1'b1;
    idle(1);
    psel    = 1'b0;
    penable = 1'b0;
    idle(3);
    xfer(1'b0, 8'h01, 8'h00, 8'h77, 1'b0, "rd_01_after_abort");
    idle(1);
`endif

    // Reset lands on an in-flight write of 0x5A to 0x07.
    xfer(1'b1, 8'h07, 8'h33, 8'h00, 1'b0, "wr_33_07");
    idle(1);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h07;
    pwdata  = 8'h5A;
`ifdef APB_SLV_WAIT_EN
    idle(1);
    penable = 1'b1;
    reset   = 1'b1;
    idle(2);
`else
    reset   = 1'b1;
    idle(1);
`endif
    reset   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    idle(2);
    xfer(1'b0, 8'h07, 8'h00, 8'h00, 1'b0, "rd_07_after_reset");
    xfer(1'b0, 8'h03, 8'h00, 8'h00, 1'b0, "rd_03_after_reset");
    idle(3);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
